// File: rtl/vua_insn_decoder.sv
// vua_insn_decoder: streaming Vua VM instruction decoder with PC tracking
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_word: instruction word stream;
//        flush/flush_pc: discard state and restart at flush_pc;
//        d_valid/d_ready: decoded bundle handshake; d_op, d_class, d_dst, d_sa, d_sb,
//        d_use_imm, d_imm, d_pc, d_err: decoded bundle fields.
// Optional feature: define VUA_DEC_STRICT_EN to flag illegal instructions on d_err.
module vua_insn_decoder #(
    parameter int NREG = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [5:0]  d_op,
    output logic [2:0]  d_class,
    output logic [7:0]  d_dst,
    output logic [7:0]  d_sa,
    output logic [7:0]  d_sb,
    output logic        d_use_imm,
    output logic [31:0] d_imm,
    output logic [31:0] d_pc,
    output logic        d_err
);
    typedef enum logic {HEAD, EXT} state_t;
    localparam logic [8:0] NR = 9'(NREG);
    state_t state, state_nx;
    logic [31:0] pc, hdr, hdr_pc, hw, imm, dpc;
    logic [5:0] op, op_o;
    logic [7:0] dst, sa, sb;
    logic i, x, accept, load, use_imm, err, reserved;
    logic [2:0] cls, cls_o;
    assign in_ready = !flush && (!d_valid || d_ready);
    assign accept = in_valid && in_ready;
    // In EXT the header comes from the latch and in_word is the extension word.
    assign hw = (state == EXT) ? hdr : in_word;
    assign {op, dst, sa, sb, i, x} = hw;
    assign dpc = (state == EXT) ? hdr_pc : pc;
    assign load = accept && (state == EXT || !in_word[0]);
    assign cls = (op == 6'h01 || op == 6'h02) ? 3'd1 :
                 (op >= 6'h08 && op <= 6'h15) ? 3'd2 :
                 (op >= 6'h18 && op <= 6'h1A) ? 3'd3 :
                 (op == 6'h20 || op == 6'h21) ? 3'd4 :
                 (op == 6'h28)                ? 3'd5 :
                 (op >= 6'h30 && op <= 6'h32) ? 3'd6 : 3'd0;
    assign reserved = cls == 3'd0 && op != 6'h00;
    assign imm = x ? in_word : i ? {{24{sb[7]}}, sb} : 32'd0;
    assign use_imm = (cls >= 3'd1 && cls <= 3'd4) ? (i | x) : cls == 3'd6;
`ifdef VUA_DEC_STRICT_EN
    function automatic logic bad(input logic [7:0] r);
        return {1'b0, r} >= NR;
    endfunction
    logic bad_reg;
    // Only register fields the class actually reads or writes are range-checked.
    always_comb begin
        bad_reg = 1'b0;
        case (cls)
            3'd1:       bad_reg = bad(dst) | (op == 6'h01 && bad(sa));
            3'd2, 3'd4: bad_reg = bad(dst) | bad(sa) | (!(i | x) && bad(sb));
            3'd3:       bad_reg = bad(dst) | bad(sa);
            3'd5:       bad_reg = bad(sa) | bad(sb);
            3'd6:       bad_reg = op != 6'h30 && bad(sa);
            default:    bad_reg = 1'b0;
        endcase
    end
    assign err = reserved | (cls == 3'd6 && !x) | (cls == 3'd5 && sb < sa) | bad_reg |
                 (op == 6'h02 && !i && !x);
    assign cls_o = err ? 3'd0 : cls;
    assign op_o = op;
`else
    logic unused_nreg;
    assign unused_nreg = ^NR;
    assign err = 1'b0;
    assign cls_o = cls;
    assign op_o = reserved ? 6'h00 : op;
`endif
    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = HEAD;
        else if (accept)
            state_nx = (state == HEAD && in_word[0]) ? EXT : HEAD;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HEAD;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            hdr <= '0;
            hdr_pc <= '0;
            d_valid <= 1'b0;
            d_op <= '0;
            d_class <= '0;
            d_dst <= '0;
            d_sa <= '0;
            d_sb <= '0;
            d_use_imm <= 1'b0;
            d_imm <= '0;
            d_pc <= '0;
            d_err <= 1'b0;
        end else if (flush) begin
            d_valid <= 1'b0;
            pc <= flush_pc;
        end else begin
            if (d_ready)
                d_valid <= 1'b0;
            if (accept)
                pc <= pc + 32'd1;
            if (accept && state == HEAD && in_word[0]) begin
                hdr <= in_word;
                hdr_pc <= pc;
            end
            if (load) begin
                d_valid <= 1'b1;
                d_op <= op_o;
                d_class <= cls_o;
                d_dst <= dst;
                d_sa <= sa;
                d_sb <= sb;
                d_use_imm <= use_imm;
                d_imm <= imm;
                d_pc <= dpc;
                d_err <= err;
            end
        end
    end
endmodule
